// File: rtl/pack_pkg.sv
// pack_pkg: shared constants, FSM state encoding and helpers for the pack
// sample-buffer readers.
//   PACK_DEPTH   - default number of buffer entries
//   PACK_HDR     - default packet sync word
//   PACK_RD_LAT  - default buffer read latency (cycles)
//   pack_state_t - packet reader FSM states
//   pack_pkt_words(n) - packet length in 32-bit words for n samples
package pack_pkg;

  localparam int unsigned PACK_DEPTH  = 4000;
  localparam logic [15:0] PACK_HDR    = 16'hEB90;
  localparam int unsigned PACK_RD_LAT = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HDR,
    ST_UTC,
    ST_NS,
    ST_SX,
    ST_SY,
    ST_SZ,
    ST_SUM
  } pack_state_t;

  // Header, utc, ns, three words per sample, checksum.
  function automatic int unsigned pack_pkt_words(input int unsigned pkt_n);
    return 4 + 3 * pkt_n;
  endfunction

endpackage

// File: rtl/pack_fill_cnt.sv
// pack_fill_cnt: number of buffer entries written but not yet read, modulo
// DEPTH. Purely combinational.
//   waddr - write pointer (next entry to be written)
//   raddr - read pointer
//   avail - entries available, 13 bits
module pack_fill_cnt
  import pack_pkg::*;
#(
  parameter int unsigned DEPTH = PACK_DEPTH
) (
  input  logic [11:0] waddr,
  input  logic [11:0] raddr,
  output logic [12:0] avail
);

  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  always_comb begin
    if (waddr >= raddr) avail = {1'b0, waddr} - {1'b0, raddr};
    else                avail = {1'b0, waddr} + DEPTH_W - {1'b0, raddr};
  end

endmodule

// File: rtl/pack_rd.sv
// pack_rd: packet reader for the pack sample buffer. Waits for PKT_N samples,
// reads them through the buffer read port and emits framed 32-bit packets
// {HDR,seq}, utc, ns, (x,y,z) * PKT_N, checksum over a valid/ready stream.
//   clk_sys, rst        - clock, asynchronous active-high reset
//   buf_waddr/buf_raddr - buffer write pointer in, read address out
//   q_x/q_y/q_z         - sample data from buffer, [23:0] significant
//   q_utc/q_ns          - time stamp of the addressed entry
//   pk_data/pk_vld/pk_rdy/pk_sop/pk_eop - packet word stream
//   pk_seq              - sequence number of the next packet
module pack_rd
  import pack_pkg::*;
#(
  parameter int unsigned DEPTH  = PACK_DEPTH,
  parameter int unsigned PKT_N  = 16,
  parameter int unsigned RD_LAT = PACK_RD_LAT,
  parameter logic [15:0] HDR    = PACK_HDR
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [11:0] buf_waddr,
  output logic [11:0] buf_raddr,
  input  logic [31:0] q_x,
  input  logic [31:0] q_y,
  input  logic [31:0] q_z,
  input  logic [31:0] q_utc,
  input  logic [31:0] q_ns,
  output logic [31:0] pk_data,
  output logic        pk_vld,
  input  logic        pk_rdy,
  output logic        pk_sop,
  output logic        pk_eop,
  output logic [15:0] pk_seq
);

  pack_state_t state;
  logic [1:0]  lat_cnt;
  logic [7:0]  samp_cnt;
  logic [23:0] h_x, h_y, h_z;
  logic [31:0] h_utc, h_ns;
  logic [31:0] csum;
  logic [12:0] avail;
  logic        accept;
  logic        unused_hi;

  pack_fill_cnt #(.DEPTH(DEPTH)) u_fill_cnt (
    .waddr (buf_waddr),
    .raddr (buf_raddr),
    .avail (avail)
  );

  assign accept    = pk_vld & pk_rdy;
  assign unused_hi = ^{q_x[31:24], q_y[31:24], q_z[31:24]};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      samp_cnt  <= '0;
      h_x       <= '0;
      h_y       <= '0;
      h_z       <= '0;
      h_utc     <= '0;
      h_ns      <= '0;
      csum      <= '0;
      buf_raddr <= '0;
      pk_data   <= '0;
      pk_vld    <= 1'b0;
      pk_sop    <= 1'b0;
      pk_eop    <= 1'b0;
      pk_seq    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (avail >= 13'(PKT_N)) begin
            state    <= ST_FETCH;
            lat_cnt  <= '0;
            samp_cnt <= '0;
          end
        end
        ST_FETCH: begin
          // RD_LAT+1 cycles here, so q_* reflects the current buf_raddr.
          if (lat_cnt == 2'(RD_LAT)) begin
            h_x    <= q_x[23:0];
            h_y    <= q_y[23:0];
            h_z    <= q_z[23:0];
            h_utc  <= q_utc;
            h_ns   <= q_ns;
            pk_vld <= 1'b1;
            if (samp_cnt == '0) begin
              state   <= ST_HDR;
              pk_data <= {HDR, pk_seq};
              pk_sop  <= 1'b1;
              csum    <= '0;
            end else begin
              state   <= ST_SX;
              pk_data <= {8'h00, q_x[23:0]};
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ST_HDR: if (accept) begin
          csum    <= csum + pk_data;
          pk_data <= h_utc;
          pk_sop  <= 1'b0;
          state   <= ST_UTC;
        end
        ST_UTC: if (accept) begin
          csum    <= csum + pk_data;
          pk_data <= h_ns;
          state   <= ST_NS;
        end
        ST_NS: if (accept) begin
          csum    <= csum + pk_data;
          pk_data <= {8'h00, h_x};
          state   <= ST_SX;
        end
        ST_SX: if (accept) begin
          csum    <= csum + pk_data;
          pk_data <= {8'h00, h_y};
          state   <= ST_SY;
        end
        ST_SY: if (accept) begin
          csum    <= csum + pk_data;
          pk_data <= {8'h00, h_z};
          state   <= ST_SZ;
        end
        ST_SZ: if (accept) begin
          csum <= csum + pk_data;
          if (buf_raddr == 12'(DEPTH - 1)) buf_raddr <= '0;
          else                             buf_raddr <= buf_raddr + 12'd1;
          if (samp_cnt == 8'(PKT_N - 1)) begin
            state   <= ST_SUM;
            // Accumulator does not yet hold this z word; fold it in here.
            pk_data <= csum + pk_data;
            pk_eop  <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            samp_cnt <= samp_cnt + 8'd1;
            lat_cnt  <= '0;
            pk_vld   <= 1'b0;
          end
        end
        ST_SUM: if (accept) begin
          pk_vld <= 1'b0;
          pk_eop <= 1'b0;
          pk_seq <= pk_seq + 16'd1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_rd.sv
// tb_pack_rd: directed self-checking bench for pack_rd (PKT_N=4, RD_LAT=2)
// with a 2-cycle buffer model, plus a second reader (PKT_N=2) walked up to
// the address wrap point.
module tb_pack_rd;
  import pack_pkg::*;

  localparam int unsigned NONE = 999;

  logic        clk_sys = 1'b0;
  logic        rst, rst2;
  logic [11:0] buf_waddr, buf_raddr, buf_waddr2, buf_raddr2;
  logic [31:0] q_x, q_y, q_z, q_utc, q_ns;
  logic [31:0] q_x2, q_y2, q_z2, q_utc2, q_ns2;
  logic [31:0] pk_data, pk_data2;
  logic        pk_vld, pk_rdy, pk_sop, pk_eop;
  logic        pk_vld2, pk_sop2, pk_eop2;
  logic [15:0] pk_seq, pk_seq2;
  logic [11:0] ra_d1, ra_d2, rb_d1, rb_d2;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  // Buffer model: entry n holds x=n, y=n+0x100, z=n+0x200, utc=0x1000+n,
  // ns=0x2000+n; upper data byte carries junk that must be dropped.
  always @(posedge clk_sys) begin
    ra_d1 <= buf_raddr;  ra_d2 <= ra_d1;
    rb_d1 <= buf_raddr2; rb_d2 <= rb_d1;
  end
  assign q_x    = {8'hA5, 12'h000, ra_d2};
  assign q_y    = {8'h5A, 24'({12'h000, ra_d2}) + 24'h000100};
  assign q_z    = {8'hC3, 24'({12'h000, ra_d2}) + 24'h000200};
  assign q_utc  = 32'h1000 + {20'h0, ra_d2};
  assign q_ns   = 32'h2000 + {20'h0, ra_d2};
  assign q_x2   = {8'hA5, 12'h000, rb_d2};
  assign q_y2   = {8'h5A, 24'({12'h000, rb_d2}) + 24'h000100};
  assign q_z2   = {8'hC3, 24'({12'h000, rb_d2}) + 24'h000200};
  assign q_utc2 = 32'h1000 + {20'h0, rb_d2};
  assign q_ns2  = 32'h2000 + {20'h0, rb_d2};

  pack_rd #(.DEPTH(4000), .PKT_N(4), .RD_LAT(2), .HDR(16'hEB90)) dut (
    .clk_sys (clk_sys), .rst (rst),
    .buf_waddr (buf_waddr), .buf_raddr (buf_raddr),
    .q_x (q_x), .q_y (q_y), .q_z (q_z), .q_utc (q_utc), .q_ns (q_ns),
    .pk_data (pk_data), .pk_vld (pk_vld), .pk_rdy (pk_rdy),
    .pk_sop (pk_sop), .pk_eop (pk_eop), .pk_seq (pk_seq)
  );

  pack_rd #(.DEPTH(4000), .PKT_N(2), .RD_LAT(2), .HDR(16'hEB90)) dut2 (
    .clk_sys (clk_sys), .rst (rst2),
    .buf_waddr (buf_waddr2), .buf_raddr (buf_raddr2),
    .q_x (q_x2), .q_y (q_y2), .q_z (q_z2), .q_utc (q_utc2), .q_ns (q_ns2),
    .pk_data (pk_data2), .pk_vld (pk_vld2), .pk_rdy (1'b1),
    .pk_sop (pk_sop2), .pk_eop (pk_eop2), .pk_seq (pk_seq2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Expected body word idx (0..14) of a PKT_N=4 packet starting at base.
  function automatic logic [31:0] exp_word(input int unsigned idx, input logic [15:0] seq,
                                           input int unsigned base);
    int unsigned s, k, a;
    if (idx == 0) return {16'hEB90, seq};
    if (idx == 1) return 32'h1000 + 32'(base);
    if (idx == 2) return 32'h2000 + 32'(base);
    s = (idx - 3) / 3;
    k = (idx - 3) % 3;
    a = (base + s) % 4000;
    return 32'(a) + 32'h100 * 32'(k);
  endfunction

  // Receives one packet, checking every word, framing and inter-word gaps.
  // stall_idx: hold pk_rdy low 5 cycles on that word; stop_idx: return
  // while that word is still presented.
  task automatic collect(input logic [15:0] seq, input int unsigned base,
                         input int unsigned stall_idx, input int unsigned stop_idx,
                         output logic [31:0] utc_w, output logic [31:0] last_w);
    int unsigned nw;
    int unsigned c;
    logic [31:0] sum, want;
    nw = pack_pkt_words(4);
    sum = '0;
    utc_w = '0;
    last_w = '0;
    for (int unsigned i = 0; i < nw; i++) begin
      c = 0;
      while (pk_vld !== 1'b1 && c < 200) begin
        @(negedge clk_sys);
        c++;
      end
      chk($sformatf("p%0d w%0d vld", seq, i), {31'b0, pk_vld}, 32'd1);
      if (i >= 6 && (i - 3) % 3 == 0 && i < nw - 1)
        chk($sformatf("p%0d w%0d gap", seq, i), c, 32'd3);
      else if (i > 0)
        chk($sformatf("p%0d w%0d gap", seq, i), c, 32'd0);
      want = (i == nw - 1) ? sum : exp_word(i, seq, base);
      if (i == stall_idx) begin
        pk_rdy = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
          @(negedge clk_sys);
          chk($sformatf("stall %0d data", k), pk_data, want);
          chk($sformatf("stall %0d vld", k), {31'b0, pk_vld}, 32'd1);
        end
        pk_rdy = 1'b1;
      end
      chk($sformatf("p%0d w%0d data", seq, i), pk_data, want);
      chk($sformatf("p%0d w%0d sop", seq, i), {31'b0, pk_sop}, {31'b0, i == 0});
      chk($sformatf("p%0d w%0d eop", seq, i), {31'b0, pk_eop}, {31'b0, i == nw - 1});
      if (i == 1) utc_w = pk_data;
      last_w = pk_data;
      sum = sum + want;
      if (i == stop_idx) return;
      @(negedge clk_sys);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " raddr"}, {20'h0, buf_raddr}, 32'd0);
    chk({tag, " data"}, pk_data, 32'd0);
    chk({tag, " vld"}, {31'b0, pk_vld}, 32'd0);
    chk({tag, " sop"}, {31'b0, pk_sop}, 32'd0);
    chk({tag, " eop"}, {31'b0, pk_eop}, 32'd0);
    chk({tag, " seq"}, {16'h0, pk_seq}, 32'd0);
  endtask

  logic [31:0] utc_w, last_w;
  logic        vld_seen;
  logic [31:0] w2 [20];
  int unsigned n2, c2;

  initial begin
    rst = 1'b1; rst2 = 1'b1; pk_rdy = 1'b1;
    buf_waddr = 12'd0; buf_waddr2 = 12'd3998;
    repeat (3) @(negedge clk_sys);
    chk_reset_outputs("reset");
    rst = 1'b0; rst2 = 1'b0;

    // Under threshold, then exact start latency.
    buf_waddr = 12'd3;
    vld_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_sys);
      if (pk_vld) vld_seen = 1'b1;
    end
    chk("under threshold vld", {31'b0, vld_seen}, 32'd0);
    buf_waddr = 12'd4;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk_sys);
      chk($sformatf("latency t+%0d vld", k), {31'b0, pk_vld}, 32'd0);
    end
    @(negedge clk_sys);
    chk("latency t+4 vld", {31'b0, pk_vld}, 32'd1);
    chk("latency t+4 hdr", pk_data, 32'hEB900000);

    // Basic packet.
    collect(16'd0, 0, NONE, NONE, utc_w, last_w);
    chk("basic checksum", last_w, 32'hEB903C12);
    chk("basic raddr", {20'h0, buf_raddr}, 32'd4);
    chk("basic seq", {16'h0, pk_seq}, 32'd1);

    // Backpressure on word 5.
    buf_waddr = 12'd8;
    collect(16'd1, 4, 5, NONE, utc_w, last_w);
    chk("stall checksum", last_w, 32'hEB903C4B);
    chk("stall raddr", {20'h0, buf_raddr}, 32'd8);
    chk("stall seq", {16'h0, pk_seq}, 32'd2);

    // Reset in the middle of a packet.
    buf_waddr = 12'd12;
    collect(16'd2, 8, NONE, 7, utc_w, last_w);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    buf_waddr = 12'd0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    buf_waddr = 12'd4;
    collect(16'd0, 0, NONE, NONE, utc_w, last_w);
    chk("after reset raddr", {20'h0, buf_raddr}, 32'd4);

    // Back-to-back packets from a fresh reset.
    rst = 1'b1;
    buf_waddr = 12'd0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    buf_waddr = 12'd12;
    collect(16'd0, 0, NONE, NONE, utc_w, last_w);
    collect(16'd1, 4, NONE, NONE, utc_w, last_w);
    collect(16'd2, 8, NONE, NONE, utc_w, last_w);
    chk("b2b third utc", utc_w, 32'h1008);
    chk("b2b seq", {16'h0, pk_seq}, 32'd3);
    chk("b2b raddr", {20'h0, buf_raddr}, 32'd12);

    // Wrap: second reader stops at 3998, then reads 3998,3999,0,1.
    c2 = 0;
    while (buf_raddr2 != 12'd3998 && c2 < 60000) begin
      @(negedge clk_sys);
      c2++;
    end
    chk("wrap reach 3998", {20'h0, buf_raddr2}, 32'd3998);
    repeat (6) @(negedge clk_sys);
    chk("wrap idle vld", {31'b0, pk_vld2}, 32'd0);
    buf_waddr2 = 12'd2;
    n2 = 0;
    c2 = 0;
    while (n2 < 20 && c2 < 2000) begin
      @(negedge clk_sys);
      c2++;
      if (pk_vld2) begin
        w2[n2] = pk_data2;
        n2++;
      end
    end
    chk("wrap word count", n2, 32'd20);
    chk("wrap p1 hdr", w2[0], 32'hEB9007CF);
    chk("wrap p1 utc", w2[1], 32'h00001F9E);
    chk("wrap p1 x0", w2[3], 32'h00000F9E);
    chk("wrap p1 x1", w2[6], 32'h00000F9F);
    chk("wrap p1 y1", w2[7], 32'h0000109F);
    chk("wrap p2 hdr", w2[10], 32'hEB9007D0);
    chk("wrap p2 utc", w2[11], 32'h00001000);
    chk("wrap p2 x0", w2[13], 32'h00000000);
    chk("wrap p2 x1", w2[16], 32'h00000001);
    chk("wrap p2 z1", w2[18], 32'h00000201);
    repeat (8) @(negedge clk_sys);
    chk("wrap final raddr", {20'h0, buf_raddr2}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
